// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cla_pkg
// Description : Shared constants and helpers for the pipelined carry-lookahead
//               adder/subtractor: operation codes, slice-width helper and a
//               constant clog2 used to size the lookahead tree depth.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package cla_pkg;

    // Operation select values for the sub input
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Ceiling log2, usable in constant expressions
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Number of result bits resolved per pipeline stage
    function automatic int slice_width(input int width, input int stages);
        return width / stages;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla_slice.sv
`default_nettype none
// ============================================================================
// Module      : cla_slice
// Description : Combinational W-bit carry-lookahead slice. Bit generate and
//               propagate terms are folded into a tree of GROUP-wide nodes
//               (upward pass), then carries are distributed back down the
//               tree from the slice carry-in (downward pass).
// Ports       : i_a, i_b   [W-1:0]  operand bits of this slice
//               i_cin               carry into bit 0 of the slice
//               o_sum      [W-1:0]  slice sum
//               o_grp_g, o_grp_p    group generate / propagate of whole slice
//               o_cout              carry out of bit W-1
//               o_msb_cin           carry into bit W-1 (for overflow detect)
// Revision    : 1.0 - initial release
// ============================================================================
module cla_slice
    import cla_pkg::*;
#(
    parameter int W     = 8,
    parameter int GROUP = 4
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_grp_g,
    output logic         o_grp_p,
    output logic         o_cout,
    output logic         o_msb_cin
);

    localparam int c_lg     = clog2(GROUP);
    // Tree levels needed so that GROUP**levels covers all W bits
    localparam int c_levels = (clog2(W) + c_lg - 1) / c_lg;
    localparam int c_npad   = 1 << (c_lg * c_levels);

    always_comb begin
        // Level l, index j holds the node covering bits [j*GROUP**l +: GROUP**l]
        logic [c_npad-1:0] v_g [c_levels+1];
        logic [c_npad-1:0] v_p [c_levels+1];
        logic [c_npad-1:0] v_c [c_levels+1];
        logic              v_gg;
        logic              v_pp;
        logic              v_cc;
        logic              v_unused;

        for (int l = 0; l <= c_levels; l++) begin
            v_g[l] = '0;
            v_p[l] = '0;
            v_c[l] = '0;
        end
        v_gg     = 1'b0;
        v_pp     = 1'b1;
        v_cc     = 1'b0;
        v_unused = 1'b0;

        // Padding bits above W propagate, so the root node equals the slice G/P
        v_g[0][W-1:0] = i_a & i_b;
        v_p[0]        = '1;
        v_p[0][W-1:0] = i_a ^ i_b;

        // Upward pass: fold GROUP children into each parent node
        for (int l = 0; l < c_levels; l++) begin
            for (int j = 0; j < (c_npad >> (c_lg * (l + 1))); j++) begin
                v_gg = 1'b0;
                v_pp = 1'b1;
                for (int k = 0; k < GROUP; k++) begin
                    v_gg = v_g[l][j*GROUP+k] | (v_p[l][j*GROUP+k] & v_gg);
                    v_pp = v_pp & v_p[l][j*GROUP+k];
                end
                v_g[l+1][j] = v_gg;
                v_p[l+1][j] = v_pp;
            end
        end

        // Downward pass: carry into each child from parent carry and lower siblings
        v_c[c_levels][0] = i_cin;
        for (int l = c_levels; l > 0; l--) begin
            for (int j = 0; j < (c_npad >> (c_lg * l)); j++) begin
                v_cc = v_c[l][j];
                for (int k = 0; k < GROUP; k++) begin
                    v_c[l-1][j*GROUP+k] = v_cc;
                    v_cc = v_g[l-1][j*GROUP+k] | (v_p[l-1][j*GROUP+k] & v_cc);
                end
            end
        end

        o_sum     = i_a ^ i_b ^ v_c[0][W-1:0];
        o_msb_cin = v_c[0][W-1];
        o_grp_g   = v_g[c_levels][0];
        o_grp_p   = v_p[c_levels][0];
        o_cout    = o_grp_g | (o_grp_p & i_cin);

        // Tree nodes above the populated range exist only for regular indexing
        for (int l = 0; l <= c_levels; l++) begin
            v_unused = v_unused ^ (^{v_g[l], v_p[l], v_c[l]});
        end
    end

endmodule
`default_nettype wire

// File: rtl/cla_pipe_addsub.sv
`default_nettype none
// ============================================================================
// Module      : cla_pipe_addsub
// Description : Pipelined carry-lookahead adder/subtractor. The WIDTH-bit
//               operation is split into STAGES slices; stage k resolves slice
//               k using the carry registered by stage k-1. Whole pipeline
//               advances together under a valid/ready handshake.
// Ports       : clk, rst            clock, asynchronous active-high reset
//               flush               drop all in-flight operations
//               in_valid/in_ready   input handshake
//               a, b [WIDTH-1:0]    operands
//               sub, cin            0: a+b+cin, 1: a-b
//               out_valid/out_ready output handshake
//               sum  [WIDTH-1:0]    result modulo 2^WIDTH
//               cout, ovf, zero     carry (no-borrow), signed overflow, sum==0
// Revision    : 1.0 - initial release
// ============================================================================
module cla_pipe_addsub
    import cla_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int GROUP  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int c_slice_w = slice_width(WIDTH, STAGES);
    localparam int c_last    = STAGES - 1;

    logic             w_adv;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c0;

    // Per-stage registers: valid, partial sum, slice carry, operands for later stages
    logic [STAGES-1:0] r_vld;
    logic [WIDTH-1:0]  r_sum [STAGES];
    logic [WIDTH-1:0]  r_a   [STAGES];
    logic [WIDTH-1:0]  r_b   [STAGES];
    logic [STAGES-1:0] r_cy;
    logic              r_ovf;
    logic              r_zero;

    // Per-stage combinational inputs and slice results
    logic [WIDTH-1:0]     w_op_a    [STAGES];
    logic [WIDTH-1:0]     w_op_b    [STAGES];
    logic [WIDTH-1:0]     w_sum_in  [STAGES];
    logic [WIDTH-1:0]     w_sum_nxt [STAGES];
    logic [c_slice_w-1:0] w_s_sum   [STAGES];
    logic [STAGES-1:0]    w_ci;
    logic [STAGES-1:0]    w_vin;
    logic [STAGES-1:0]    w_s_co;
    logic [STAGES-1:0]    w_s_mci;
    logic [STAGES-1:0]    w_s_g;
    logic [STAGES-1:0]    w_s_p;
    logic                 w_unused;

    // The pipe only moves as a whole; a held result blocks everything behind it
    assign w_adv    = !r_vld[c_last] | out_ready;
    assign in_ready = w_adv;

    // Subtraction is a + ~b + 1; add-mode carry-in is ignored when subtracting
    assign w_b_eff = (sub == OP_SUB) ? ~b : b;
    assign w_c0    = (sub == OP_ADD) ? cin : 1'b1;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign w_op_a[k]   = a;
            assign w_op_b[k]   = w_b_eff;
            assign w_ci[k]     = w_c0;
            assign w_sum_in[k] = '0;
            assign w_vin[k]    = in_valid;
        end else begin : g_rest
            assign w_op_a[k]   = r_a[k-1];
            assign w_op_b[k]   = r_b[k-1];
            assign w_ci[k]     = r_cy[k-1];
            assign w_sum_in[k] = r_sum[k-1];
            assign w_vin[k]    = r_vld[k-1];
        end

        cla_slice #(
            .W     (c_slice_w),
            .GROUP (GROUP)
        ) u_slice (
            .i_a       (w_op_a[k][k*c_slice_w +: c_slice_w]),
            .i_b       (w_op_b[k][k*c_slice_w +: c_slice_w]),
            .i_cin     (w_ci[k]),
            .o_sum     (w_s_sum[k]),
            .o_grp_g   (w_s_g[k]),
            .o_grp_p   (w_s_p[k]),
            .o_cout    (w_s_co[k]),
            .o_msb_cin (w_s_mci[k])
        );
    end

    // Merge this stage's slice into the already-resolved low bits
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_sum_nxt[k] = w_sum_in[k];
            w_sum_nxt[k][k*c_slice_w +: c_slice_w] = w_s_sum[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld  <= '0;
            r_cy   <= '0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b1;
            for (int k = 0; k < STAGES; k++) begin
                r_sum[k] <= '0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
            end
        end else begin
            if (flush) begin
                r_vld <= '0;
            end else if (w_adv) begin
                r_vld <= w_vin;
            end
            // Data only loads for real operations so outputs hold across bubbles
            for (int k = 0; k < STAGES; k++) begin
                if (w_adv && w_vin[k]) begin
                    r_sum[k] <= w_sum_nxt[k];
                    r_cy[k]  <= w_s_co[k];
                    r_a[k]   <= w_op_a[k];
                    r_b[k]   <= w_op_b[k];
                end
            end
            if (w_adv && w_vin[c_last]) begin
                r_ovf  <= w_s_co[c_last] ^ w_s_mci[c_last];
                r_zero <= (w_sum_nxt[c_last] == '0);
            end
        end
    end

    assign out_valid = r_vld[c_last];
    assign sum       = r_sum[c_last];
    assign cout      = r_cy[c_last];
    assign ovf       = r_ovf;
    assign zero      = r_zero;

    // Group G/P and operand bits outside a stage's slice are structurally unread
    always_comb begin
        w_unused = ^{w_s_g, w_s_p, w_s_mci};
        for (int k = 0; k < STAGES; k++) begin
            w_unused = w_unused ^ (^{w_op_a[k], w_op_b[k], w_sum_in[k], r_a[k], r_b[k]});
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe_addsub.sv
`default_nettype none
// ============================================================================
// Module      : tb_cla_pipe_addsub
// Description : Self-checking bench for cla_pipe_addsub. Accepted operations
//               are turned into expected results with plain integer
//               arithmetic and queued; every output transfer is compared
//               against the queue head, including latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_pipe_addsub;

    localparam int WIDTH  = 32;
    localparam int STAGES = 2;
    localparam int GROUP  = 4;

    localparam longint c_mod  = longint'(1) << WIDTH;
    localparam longint c_half = longint'(1) << (WIDTH - 1);

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic             zero;
        int               t;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   lat_exact  = 1'b1;
    bit   rand_ready = 1'b0;

    cla_pipe_addsub #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES),
        .GROUP  (GROUP)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, expv, cyc);
        end
    endtask

    // Reference: unsigned sum/difference for sum and carry, signed range for overflow
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic s, input logic c, input int t);
        exp_t   e;
        longint ua, ub, sa, sb, full, r;
        ua = longint'(x);
        ub = longint'(y);
        sa = (ua >= c_half) ? ua - c_mod : ua;
        sb = (ub >= c_half) ? ub - c_mod : ub;
        if (!s) begin
            full   = ua + ub + longint'(c);
            e.cout = (full >= c_mod);
            r      = sa + sb + longint'(c);
        end else begin
            full   = ua - ub;
            e.cout = (ua >= ub);
            r      = sa - sb;
        end
        e.sum  = WIDTH'(full);
        e.ovf  = (r < -c_half) || (r > c_half - 1);
        e.zero = (e.sum == '0);
        e.t    = t;
        return e;
    endfunction

    // Monitor: all handshake decisions are taken from values stable at negedge
    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (q.size() == 0) begin
                check_value("spurious_out", out_valid, 64'd0);
            end else begin
                e = q.pop_front();
                check_value("sum",  sum,  e.sum);
                check_value("cout", cout, e.cout);
                check_value("ovf",  ovf,  e.ovf);
                check_value("zero", zero, e.zero);
                if (lat_exact) check_value("latency", cyc - e.t, STAGES);
                else           check_value("latency_min", (cyc - e.t) >= STAGES, 64'd1);
            end
        end else if (out_valid === 1'b1) begin
            check_value("stall_in_ready", in_ready, 64'd0);
            if (q.size() > 0) check_value("stall_sum", sum, q[0].sum);
        end
        if (rst || flush) q.delete();
        else if (in_valid && in_ready) q.push_back(model(a, b, sub, cin, cyc));
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic s, input logic c);
        logic acc;
        acc = 1'b0;
        a = x; b = y; sub = s; cin = c; in_valid = 1'b1;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!acc) check_value("send_timeout", acc, 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && q.size() != 0; i++) tick();
        check_value("drain", q.size(), 64'd0);
    endtask

    task automatic expect_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_value("idle_out_valid", out_valid, 64'd0);
            tick();
        end
    endtask

    function automatic logic [WIDTH-1:0] rnd_op();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return {1'b0, {(WIDTH-1){1'b1}}};
            3:       return {1'b1, {(WIDTH-1){1'b0}}};
            default: return r[WIDTH-1:0];
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; sub = 1'b0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check_value("rst_out_valid", out_valid, 64'd0);
        check_value("rst_sum",       sum,       64'd0);
        check_value("rst_cout",      cout,      64'd0);
        check_value("rst_ovf",       ovf,       64'd0);
        check_value("rst_zero",      zero,      64'd1);
        check_value("rst_in_ready",  in_ready,  64'd1);
        tick();

        // Basic add and boundary cases
        send(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0);
        drain();
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        send(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0);
        send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
        send(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        drain();

        // Back-to-back stream at full throughput
        for (int i = 0; i < 8; i++) send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        drain();

        // Stream with a three-cycle consumer stall in the middle
        lat_exact = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            begin
                repeat (4) tick();
                out_ready = 1'b0;
                repeat (3) tick();
                out_ready = 1'b1;
            end
        join
        drain();
        lat_exact = 1'b1;

        // Flush with two operations in flight; input in the flush cycle is dropped
        send(32'h0000_1111, 32'h0000_2222, 1'b0, 1'b0);
        send(32'h0000_3333, 32'h0000_4444, 1'b0, 1'b0);
        flush = 1'b1; in_valid = 1'b1; a = 32'h55; b = 32'h66;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        expect_idle(STAGES + 2);
        send(32'h0000_00AA, 32'h0000_0055, 1'b0, 1'b1);
        drain();

        // Asynchronous reset mid-cycle with two operations in flight
        send(32'h0000_1000, 32'h0000_0001, 1'b0, 1'b0);
        send(32'h0000_2000, 32'h0000_0002, 1'b1, 1'b0);
        #3 rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        expect_idle(STAGES + 2);
        check_value("post_rst_zero", zero, 64'd1);
        send(32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0);
        drain();

        // Random operations with random consumer back-pressure
        lat_exact  = 1'b0;
        rand_ready = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) tick();
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        drain();

        // Random operations at full throughput with exact latency
        lat_exact = 1'b1;
        for (int i = 0; i < 500; i++) begin
            send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
